game_score: RTL and testbench
=============================

Name: game_score

Overview:
- Consumer end of the game-speed generator.
- Edge-detects the generator's toggling `game_clk` into a one-cycle `game_tick` for the scroll/obstacle logic.
- Accumulates the generator's `score_up` pulses into a BCD score.
- Runs the IDLE/RUN/OVER game state machine and keeps a high score.
- Outputs feed the 7-segment/LCD display driver.

Parameters:
- DIGITS, 4, number of BCD digits in score and high score (score width = 4*DIGITS).
- LOCK_CYCLES, 50000000, clk cycles after entering OVER during which `start` is ignored.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- game_clk  input  1  toggling level from speed generator, same clock domain.
- score_up  input  1  one-cycle score pulse from speed generator.
- start  input  1  level/pulse from debounced button; sampled each cycle.
- collision  input  1  level from hit detector.
- game_tick  output  1  one-cycle pulse on each game_clk rising edge, RUN only.
- score_bcd  output  4*DIGITS  current score, digit 0 in [3:0].
- high_bcd  output  4*DIGITS  best score since reset.
- state  output  2  0=IDLE, 1=RUN, 2=OVER.
- new_record  output  1  high while in OVER if the last game set a new high score.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, score_bcd=0, high_bcd=0, new_record=0, game_tick=0.
  - game_clk edge register=0, lock counter=0.
- Edge detect:
  - One register holds previous game_clk.
  - game_tick=1 for exactly one cycle when prev=0 and game_clk=1 and state==RUN (registered, latency 1 cycle after the edge is sampled).
  - Ticks in IDLE/OVER are suppressed.
- IDLE: score held at 0. start=1 -> RUN next cycle.
- RUN:
  - score_up=1 -> score increments by 1 in BCD on the next edge.
  - Each digit rolls 9->0 with carry into the next digit.
  - At all-9s (9999 for DIGITS=4) the score saturates; no wrap.
  - collision=1 -> OVER next cycle.
  - Simultaneous collision and score_up: collision wins, the increment is discarded.
  - start is ignored in RUN.
- Entering OVER (same edge as the RUN->OVER transition):
  - If score_bcd > high_bcd (BCD compare, MSD first): high_bcd<=score_bcd and new_record<=1; else new_record<=0.
  - Lock counter loads LOCK_CYCLES-1.
- OVER:
  - score frozen; lock counter decrements to 0.
  - start accepted only when counter==0 -> RUN.
  - On that transition score_bcd<=0 and new_record<=0.
  - start during lock is dropped, not queued.
- State encoding 3 is illegal and recovers to IDLE on the next cycle.
- Reset mid-game: everything, including high_bcd, returns to reset values immediately.
- No combinational path from any input to any output.

Optional Feature:
- Macro: GAME_SCORE_HIGH_EN.
- Defined: high-score register, compare, and new_record exactly as above.
- Undefined: no compare logic; high_bcd and new_record are constant 0; all other behaviour identical.

Decomposition:
- Shared package `game_pkg`:
  - state encodings ST_IDLE/ST_RUN/ST_OVER.
  - BCD_MAX_DIGIT=4'd9.
  - default LOCK_CYCLES constant.
- Sub-module `bcd_digit_inc`:
  - inputs: 4-bit digit, carry_in.
  - outputs: next digit, carry_out.
  - instantiated DIGITS times in a generate chain.
  - saturation is detected at top level as carry out of the last digit.

Test Plan (LOCK_CYCLES=8 for simulation):
1. Reset low mid-RUN with score=0042 -> all outputs 0, state=IDLE, within the same cycle (async).
2. start in IDLE, then 15 score_up pulses -> score_bcd=16'h0015; 9 more -> 16'h0024 (digit carry 9->0 verified).
3. Preload to 9998, 3 score_up pulses -> 9999 held (saturation, no wrap).
4. score_up and collision asserted in the same cycle at score 0007 -> state=OVER, score stays 0007, high_bcd=0007, new_record=1.
5. In OVER, start at lock cycles 2 and 5 -> ignored. start after 8 cycles -> RUN, score=0, new_record=0. Next game ends at 0003 -> high_bcd stays 0007, new_record=0.
6. Toggle game_clk with period 4 clk in RUN -> game_tick pulses 1 cycle per rising edge. Same stimulus in IDLE/OVER -> no pulses.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game_score consumer block: state encodings,
// BCD digit limit and the default post-game start lockout length.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    localparam logic [3:0]  BCD_MAX_DIGIT       = 4'd9;
    localparam int unsigned LOCK_CYCLES_DEFAULT = 50_000_000;

endpackage : game_pkg

// File: rtl/bcd_digit_inc.sv
// Single BCD digit incrementer; chained through carry to build a
// multi-digit +1 on the score.
module bcd_digit_inc
    import game_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       carry_in,
    output logic [3:0] digit_out,
    output logic       carry_out
);

    // Add carry_in to the digit, rolling 9 -> 0 and raising carry_out.
    always_comb begin
        digit_out = digit_in;
        carry_out = 1'b0;
        if (carry_in) begin
            if (digit_in >= BCD_MAX_DIGIT) begin
                digit_out = '0;
                carry_out = 1'b1;
            end else begin
                digit_out = digit_in + 4'd1;
            end
        end
    end

endmodule : bcd_digit_inc

// File: rtl/game_score.sv
// Game score / state consumer of the speed generator.
// Turns game_clk rising edges into one-cycle game_tick pulses while running,
// accumulates score_up pulses into a saturating BCD score, sequences
// IDLE/RUN/OVER with a start lockout after each game, and optionally keeps a
// high score with a new-record flag (enabled by defining GAME_SCORE_HIGH_EN;
// otherwise high_bcd and new_record are tied to 0).
// All outputs come straight from flops.
module game_score
    import game_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_clk,
    input  logic                  score_up,
    input  logic                  start,
    input  logic                  collision,
    output logic                  game_tick,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [1:0]            state,
    output logic                  new_record
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);

    game_state_e   state_q, state_d;
    logic [SW-1:0] score_q, score_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          gclk_prev_q, gclk_prev_d;
    logic          tick_q, tick_d;

    logic [SW-1:0] score_inc;
    logic [DIGITS:0] carry;
    logic          score_sat;

    // BCD +1 chain; carry out of the top digit means the score is all 9s.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_inc u_digit (
            .digit_in  (score_q[4*g +: 4]),
            .carry_in  (carry[g]),
            .digit_out (score_inc[4*g +: 4]),
            .carry_out (carry[g+1])
        );
    end

    assign score_sat = carry[DIGITS];

    // Rising-edge detect of game_clk, only forwarded while a game is running.
    always_comb begin
        gclk_prev_d = game_clk;
        tick_d      = game_clk & ~gclk_prev_q & (state_q == ST_RUN);
    end

    // Game FSM next-state, score accumulation and post-game lockout counter.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lock_d  = lock_q;
        case (state_q)
            ST_IDLE: begin
                score_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Collision has priority: a coincident score_up is dropped.
                if (collision) begin
                    state_d = ST_OVER;
                    lock_d  = LOCK_LOAD;
                end else if (score_up && !score_sat) begin
                    score_d = score_inc;
                end
            end
            ST_OVER: begin
                if (lock_q != '0) begin
                    lock_d = lock_q - LW'(1);
                end else if (start) begin
                    state_d = ST_RUN;
                    score_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                score_d = '0;
                lock_d  = '0;
            end
        endcase
    end

    // State, score, lockout and edge-detect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            lock_q      <= '0;
            gclk_prev_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lock_q      <= lock_d;
            gclk_prev_q <= gclk_prev_d;
            tick_q      <= tick_d;
        end
    end

    assign game_tick = tick_q;
    assign score_bcd = score_q;
    assign state     = state_q;

`ifdef GAME_SCORE_HIGH_EN
    logic [SW-1:0] high_q, high_d;
    logic          rec_q, rec_d;
    logic          entering_over;
    logic          restarting;

    // Same transition conditions as the FSM, decoded locally so the default
    // build carries no trace of the high-score path.
    assign entering_over = (state_q == ST_RUN) && collision;
    assign restarting    = (state_q == ST_OVER) && start && (lock_q == '0);

    // High-score capture at game end; valid BCD orders like binary, MSD first.
    always_comb begin
        high_d = high_q;
        rec_d  = rec_q;
        if (entering_over) begin
            if (score_q > high_q) begin
                high_d = score_q;
                rec_d  = 1'b1;
            end else begin
                rec_d  = 1'b0;
            end
        end else if (restarting) begin
            rec_d = 1'b0;
        end
    end

    // High score and new-record flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            high_q <= '0;
            rec_q  <= 1'b0;
        end else begin
            high_q <= high_d;
            rec_q  <= rec_d;
        end
    end

    assign high_bcd   = high_q;
    assign new_record = rec_q;
`else
    assign high_bcd   = '0;
    assign new_record = 1'b0;
`endif

endmodule : game_score

// File: tb/tb_game_score.sv
// Directed self-checking bench for game_score (DIGITS=4, LOCK_CYCLES=8).
// High-score expectations follow GAME_SCORE_HIGH_EN.
module tb_game_score;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned LOCK   = 8;
`ifdef GAME_SCORE_HIGH_EN
    localparam logic HIGH_ON = 1'b1;
`else
    localparam logic HIGH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        game_clk = 1'b0;
    logic        score_up = 1'b0;
    logic        start = 1'b0;
    logic        collision = 1'b0;
    logic        game_tick;
    logic [15:0] score_bcd;
    logic [15:0] high_bcd;
    logic [1:0]  state;
    logic        new_record;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    game_score #(
        .DIGITS      (DIGITS),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_clk   (game_clk),
        .score_up   (score_up),
        .start      (start),
        .collision  (collision),
        .game_tick  (game_tick),
        .score_bcd  (score_bcd),
        .high_bcd   (high_bcd),
        .state      (state),
        .new_record (new_record)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; game_clk = 1'b0; score_up = 1'b0; start = 1'b0; collision = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic start_game();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            score_up = 1'b1; cycle(); score_up = 1'b0; cycle();
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_high;
        do_reset();
        checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else passes++;
        checks++; if (score_bcd !== 16'h0000) $display("FAIL reset_score: got %h expected 0000", score_bcd); else passes++;
        checks++; if (high_bcd !== 16'h0000) $display("FAIL reset_high: got %h expected 0000", high_bcd); else passes++;
        checks++; if (new_record !== 1'b0) $display("FAIL reset_rec: got %b expected 0", new_record); else passes++;
        checks++; if (game_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", game_tick); else passes++;
        // One short game to put something in the high score, then a second to 42.
        start_game(); pulses(5);
        collision = 1'b1; cycle(); collision = 1'b0;
        repeat (LOCK) cycle();
        start_game(); pulses(42);
        exp_high = HIGH_ON ? 16'h0005 : 16'h0000;
        checks++; if (score_bcd !== 16'h0042) $display("FAIL pre_rst_score: got %h expected 0042", score_bcd); else passes++;
        checks++; if (high_bcd !== exp_high) $display("FAIL pre_rst_high: got %h expected %h", high_bcd, exp_high); else passes++;
        checks++; if (state !== 2'd1) $display("FAIL pre_rst_state: got %0d expected 1", state); else passes++;
        // Assert reset between clock edges; outputs must clear without an edge.
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) $display("FAIL async_state: got %0d expected 0", state); else passes++;
        checks++; if (score_bcd !== 16'h0000) $display("FAIL async_score: got %h expected 0000", score_bcd); else passes++;
        checks++; if (high_bcd !== 16'h0000) $display("FAIL async_high: got %h expected 0000", high_bcd); else passes++;
        checks++; if (new_record !== 1'b0) $display("FAIL async_rec: got %b expected 0", new_record); else passes++;
    endtask

    task automatic test_bcd_carry();
        do_reset();
        start = 1'b1; cycle();
        checks++; if (state !== 2'd1) $display("FAIL idle_to_run: got %0d expected 1", state); else passes++;
        // start held high while running must be harmless.
        cycle(); start = 1'b0;
        checks++; if (state !== 2'd1) $display("FAIL start_in_run: got %0d expected 1", state); else passes++;
        pulses(15);
        checks++; if (score_bcd !== 16'h0015) $display("FAIL score_15: got %h expected 0015", score_bcd); else passes++;
        pulses(9);
        checks++; if (score_bcd !== 16'h0024) $display("FAIL score_24: got %h expected 0024", score_bcd); else passes++;
        pulses(76);
        checks++; if (score_bcd !== 16'h0100) $display("FAIL score_100: got %h expected 0100", score_bcd); else passes++;
    endtask

    task automatic test_saturation();
        do_reset();
        start_game();
        score_up = 1'b1;
        repeat (9998) cycle();
        score_up = 1'b0;
        checks++; if (score_bcd !== 16'h9998) $display("FAIL score_9998: got %h expected 9998", score_bcd); else passes++;
        pulses(3);
        checks++; if (score_bcd !== 16'h9999) $display("FAIL score_sat: got %h expected 9999", score_bcd); else passes++;
        checks++; if (state !== 2'd1) $display("FAIL sat_state: got %0d expected 1", state); else passes++;
    endtask

    task automatic test_collision_lock();
        logic [15:0] exp_high;
        exp_high = HIGH_ON ? 16'h0007 : 16'h0000;
        do_reset();
        start_game(); pulses(7);
        checks++; if (score_bcd !== 16'h0007) $display("FAIL score_7: got %h expected 0007", score_bcd); else passes++;
        score_up = 1'b1; collision = 1'b1; cycle(); score_up = 1'b0; collision = 1'b0;
        checks++; if (state !== 2'd2) $display("FAIL over_state: got %0d expected 2", state); else passes++;
        checks++; if (score_bcd !== 16'h0007) $display("FAIL over_score: got %h expected 0007", score_bcd); else passes++;
        checks++; if (high_bcd !== exp_high) $display("FAIL over_high: got %h expected %h", high_bcd, exp_high); else passes++;
        checks++; if (new_record !== HIGH_ON) $display("FAIL over_rec: got %b expected %b", new_record, HIGH_ON); else passes++;
        // Lockout: start at cycles 2, 5 and the last locked cycle 7 is dropped.
        for (int k = 1; k <= 7; k++) begin
            start    = (k == 2 || k == 5 || k == 7);
            score_up = (k == 3);
            cycle();
            start = 1'b0; score_up = 1'b0;
            checks++; if (state !== 2'd2) $display("FAIL lock_state_%0d: got %0d expected 2", k, state); else passes++;
            checks++; if (score_bcd !== 16'h0007) $display("FAIL lock_score_%0d: got %h expected 0007", k, score_bcd); else passes++;
        end
        checks++; if (new_record !== HIGH_ON) $display("FAIL lock_rec: got %b expected %b", new_record, HIGH_ON); else passes++;
        start = 1'b1; cycle(); start = 1'b0;
        checks++; if (state !== 2'd1) $display("FAIL restart_state: got %0d expected 1", state); else passes++;
        checks++; if (score_bcd !== 16'h0000) $display("FAIL restart_score: got %h expected 0000", score_bcd); else passes++;
        checks++; if (new_record !== 1'b0) $display("FAIL restart_rec: got %b expected 0", new_record); else passes++;
        pulses(3);
        checks++; if (score_bcd !== 16'h0003) $display("FAIL score_3: got %h expected 0003", score_bcd); else passes++;
        collision = 1'b1; cycle(); collision = 1'b0;
        checks++; if (state !== 2'd2) $display("FAIL over2_state: got %0d expected 2", state); else passes++;
        checks++; if (score_bcd !== 16'h0003) $display("FAIL over2_score: got %h expected 0003", score_bcd); else passes++;
        checks++; if (high_bcd !== exp_high) $display("FAIL over2_high: got %h expected %h", high_bcd, exp_high); else passes++;
        checks++; if (new_record !== 1'b0) $display("FAIL over2_rec: got %b expected 0", new_record); else passes++;
    endtask

    // game_clk with period 4 clk; a tick is expected the cycle after each
    // sampled rising edge, and only when active.
    task automatic toggle_game_clk(input logic active, input string phase);
        logic prev_m;
        logic gc;
        logic exp_tick;
        int   ticks;
        int   exp_ticks;
        prev_m = game_clk;
        ticks  = 0;
        for (int i = 0; i < 16; i++) begin
            gc = ((i % 4) >= 2);
            game_clk = gc;
            cycle();
            exp_tick = active & gc & ~prev_m;
            prev_m = gc;
            if (game_tick === 1'b1) ticks++;
            checks++; if (game_tick !== exp_tick) $display("FAIL tick_%s_%0d: got %b expected %b", phase, i, game_tick, exp_tick); else passes++;
        end
        game_clk = 1'b0; cycle(); cycle();
        exp_ticks = active ? 4 : 0;
        checks++; if (ticks !== exp_ticks) $display("FAIL tick_count_%s: got %0d expected %0d", phase, ticks, exp_ticks); else passes++;
    endtask

    task automatic test_game_tick();
        do_reset();
        toggle_game_clk(1'b0, "idle");
        start_game();
        checks++; if (state !== 2'd1) $display("FAIL tick_run_state: got %0d expected 1", state); else passes++;
        toggle_game_clk(1'b1, "run");
        collision = 1'b1; cycle(); collision = 1'b0;
        checks++; if (state !== 2'd2) $display("FAIL tick_over_state: got %0d expected 2", state); else passes++;
        toggle_game_clk(1'b0, "over");
    endtask

    initial begin
        test_reset();
        test_bcd_carry();
        test_saturation();
        test_collision_lock();
        test_game_tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_game_score
